// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions: branch/jump opcodes and fetch FSM state encoding.
// Imported by the fetch unit and by the branch unit.
package fetch_unit_pkg;

    localparam logic [4:0] OP_BNE  = 5'b10011;
    localparam logic [4:0] OP_BE   = 5'b10100;
    localparam logic [4:0] OP_BNER = 5'b10101;
    localparam logic [4:0] OP_BER  = 5'b10110;
    localparam logic [4:0] OP_J    = 5'b10111;
    localparam logic [4:0] OP_JR   = 5'b11000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_VALID = 2'd3;

    // Branch/jump opcodes form one contiguous range, BNE through JR.
    function automatic logic is_branch_op(input logic [4:0] op);
        return (op >= OP_BNE) && (op <= OP_JR);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port plus the ir handoff to decode.
// Handshake: ir/npc/is_branch transfer on a rising edge where ir_valid=1 and ir_ready=1;
// while ir_valid=1 and ir_ready=0 they are held. imem_addr is stable from imem_req until imem_ack.
interface fetch_unit_if;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] ir;
    logic [7:0]  npc;
    logic        ir_valid;
    logic        ir_ready;
    logic        is_branch;
    logic        redirect;
    logic [7:0]  target;

    modport master (
        output imem_addr, imem_req, ir, npc, ir_valid, is_branch,
        input  imem_ack, imem_data, ir_ready, redirect, target
    );

    modport slave (
        input  imem_addr, imem_req, ir, npc, ir_valid, is_branch,
        output imem_ack, imem_data, ir_ready, redirect, target
    );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// 8-bit program counter with load and modulo-256 increment; load wins over increment.
module pc_reg #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc,
    output logic [7:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + 8'd1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: requests imem at pc, hands the word to decode with npc,
// and restarts at a redirect target, draining any request already in flight.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus,
    output logic [1:0]   dbg_state
);

    logic [1:0]  state, state_n;
    logic [7:0]  pc;
    logic [7:0]  pend, pend_n;
    logic [15:0] ir_q;
    logic [7:0]  npc_q;
    logic        pc_load;
    logic [7:0]  pc_load_val;
    logic        pc_inc;
    logic        ir_load;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    always_comb begin
        state_n     = state;
        pend_n      = pend;
        pc_load     = 1'b0;
        pc_load_val = bus.target;
        pc_inc      = 1'b0;
        ir_load     = 1'b0;
        case (state)
            ST_IDLE: begin
                state_n = ST_REQ;
                pc_load = bus.redirect;
            end
            ST_REQ: begin
                if (bus.imem_ack) begin
                    if (bus.redirect) begin
                        pc_load = 1'b1;
                    end else begin
                        ir_load = 1'b1;
                        pc_inc  = 1'b1;
                        state_n = ST_VALID;
                    end
                end else if (bus.redirect) begin
                    // Memory still owes us a word; keep the address until it arrives.
                    pend_n  = bus.target;
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.redirect) begin
                    pend_n = bus.target;
                end
                if (bus.imem_ack) begin
                    pc_load     = 1'b1;
                    pc_load_val = bus.redirect ? bus.target : pend;
                    state_n     = ST_REQ;
                end
            end
            ST_VALID: begin
                if (bus.redirect) begin
                    pc_load = 1'b1;
                    state_n = ST_REQ;
                end else if (bus.ir_ready) begin
                    state_n = ST_REQ;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pend  <= 8'h00;
            ir_q  <= 16'h0000;
            npc_q <= 8'h00;
        end else begin
            state <= state_n;
            pend  <= pend_n;
            if (ir_load) begin
                ir_q  <= bus.imem_data;
                npc_q <= pc + 8'd1;
            end
        end
    end

    assign bus.imem_addr = pc;
    assign bus.imem_req  = (state == ST_REQ) || (state == ST_DRAIN);
    assign bus.ir_valid  = (state == ST_VALID);
    assign bus.ir        = ir_q;
    assign bus.npc       = npc_q;
    assign bus.is_branch = bus.ir_valid && is_branch_op(ir_q[15:11]);
    assign dbg_state     = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a scoreboarded random stream.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  dbg_state;
    logic [15:0] mem [256];
    logic [23:0] exp_q[$];
    int          tests_run;
    int          failed;

    fetch_unit_if ifc ();

    fetch_unit #(.RESET_PC(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifc.master),
        .dbg_state (dbg_state)
    );

    // Memory model: data always reflects the addressed word; ack timing is driven by the tests.
    assign ifc.imem_data = mem[ifc.imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_br(input logic [15:0] w);
        return (w[15:11] >= 5'd19) && (w[15:11] <= 5'd24);
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        tests_run++; if (ifc.imem_req !== 1'b0) begin failed++; $display("FAIL reset_req: got %b want 0", ifc.imem_req); end
        tests_run++; if (ifc.ir_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", ifc.ir_valid); end
        tests_run++; if (ifc.ir !== 16'h0000) begin failed++; $display("FAIL reset_ir: got %h want 0000", ifc.ir); end
        tests_run++; if (ifc.npc !== 8'h00) begin failed++; $display("FAIL reset_npc: got %h want 00", ifc.npc); end
        tests_run++; if (ifc.imem_addr !== 8'h00) begin failed++; $display("FAIL reset_addr: got %h want 00", ifc.imem_addr); end
        tests_run++; if (ifc.is_branch !== 1'b0) begin failed++; $display("FAIL reset_br: got %b want 0", ifc.is_branch); end
        tests_run++; if (dbg_state !== ST_IDLE) begin failed++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_first_fetch;
        ifc.imem_ack = 1'b1;
        rst_n = 1'b1;
        #1;
        tests_run++; if (ifc.imem_req !== 1'b0) begin failed++; $display("FAIL idle_req: got %b want 0", ifc.imem_req); end
        tick;
        tests_run++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 8'h00) begin failed++; $display("FAIL first_req: got req=%b addr=%h want 1/00", ifc.imem_req, ifc.imem_addr); end
        tests_run++; if (ifc.ir_valid !== 1'b0) begin failed++; $display("FAIL first_req_valid: got %b want 0", ifc.ir_valid); end
        tick;
        tests_run++; if (ifc.ir !== 16'hA005 || ifc.npc !== 8'h01) begin failed++; $display("FAIL first_ir: got %h/%h want a005/01", ifc.ir, ifc.npc); end
        tests_run++; if (ifc.ir_valid !== 1'b1 || ifc.is_branch !== 1'b1) begin failed++; $display("FAIL first_flags: got v=%b br=%b want 1/1", ifc.ir_valid, ifc.is_branch); end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 3; i++) begin
            tick;
            tests_run++;
            if (ifc.ir !== 16'hA005 || ifc.npc !== 8'h01 || ifc.ir_valid !== 1'b1 || ifc.imem_req !== 1'b0) begin
                failed++; $display("FAIL hold_%0d: got ir=%h npc=%h v=%b req=%b want a005/01/1/0", i, ifc.ir, ifc.npc, ifc.ir_valid, ifc.imem_req);
            end
        end
        ifc.ir_ready = 1'b1;
        tick;
        ifc.ir_ready = 1'b0;
        tests_run++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 8'h01 || ifc.ir_valid !== 1'b0) begin failed++; $display("FAIL hold_release: got req=%b addr=%h v=%b want 1/01/0", ifc.imem_req, ifc.imem_addr, ifc.ir_valid); end
        tests_run++; if (ifc.is_branch !== 1'b0) begin failed++; $display("FAIL br_invalid: got %b want 0", ifc.is_branch); end
        tick;
        tests_run++; if (ifc.ir !== mem[1] || ifc.npc !== 8'h02 || ifc.ir_valid !== 1'b1) begin failed++; $display("FAIL second_ir: got %h/%h want %h/02", ifc.ir, ifc.npc, mem[1]); end
    endtask

    task automatic test_redirect_valid;
        ifc.redirect = 1'b1; ifc.target = 8'h20; ifc.ir_ready = 1'b1;
        tick;
        ifc.redirect = 1'b0; ifc.ir_ready = 1'b0;
        tests_run++; if (ifc.ir_valid !== 1'b0 || ifc.imem_req !== 1'b1 || ifc.imem_addr !== 8'h20) begin failed++; $display("FAIL rv_req: got v=%b req=%b addr=%h want 0/1/20", ifc.ir_valid, ifc.imem_req, ifc.imem_addr); end
        tick;
        tests_run++; if (ifc.ir !== mem[8'h20] || ifc.npc !== 8'h21 || ifc.ir_valid !== 1'b1) begin failed++; $display("FAIL rv_ir: got %h/%h want %h/21", ifc.ir, ifc.npc, mem[8'h20]); end
    endtask

    task automatic test_wrap;
        ifc.redirect = 1'b1; ifc.target = 8'hFF;
        tick;
        ifc.redirect = 1'b0;
        tests_run++; if (ifc.imem_addr !== 8'hFF || ifc.imem_req !== 1'b1) begin failed++; $display("FAIL wrap_req: got addr=%h req=%b want ff/1", ifc.imem_addr, ifc.imem_req); end
        tick;
        tests_run++; if (ifc.ir !== mem[8'hFF] || ifc.npc !== 8'h00 || ifc.ir_valid !== 1'b1) begin failed++; $display("FAIL wrap_ir: got %h/%h want %h/00", ifc.ir, ifc.npc, mem[8'hFF]); end
        tests_run++; if (ifc.is_branch !== exp_br(mem[8'hFF])) begin failed++; $display("FAIL wrap_br: got %b want %b", ifc.is_branch, exp_br(mem[8'hFF])); end
        ifc.ir_ready = 1'b1;
        tick;
        ifc.ir_ready = 1'b0;
        tests_run++; if (ifc.imem_addr !== 8'h00 || ifc.imem_req !== 1'b1) begin failed++; $display("FAIL wrap_next: got addr=%h req=%b want 00/1", ifc.imem_addr, ifc.imem_req); end
        tick;
        tests_run++; if (ifc.ir !== 16'hA005 || ifc.npc !== 8'h01) begin failed++; $display("FAIL wrap_ir0: got %h/%h want a005/01", ifc.ir, ifc.npc); end
    endtask

    task automatic test_redirect_req;
        ifc.imem_ack = 1'b0; ifc.ir_ready = 1'b1;
        tick;
        ifc.ir_ready = 1'b0; ifc.redirect = 1'b1; ifc.target = 8'h40;
        tick;
        ifc.redirect = 1'b0;
        tests_run++; if (dbg_state !== ST_DRAIN || ifc.imem_addr !== 8'h01 || ifc.imem_req !== 1'b1) begin failed++; $display("FAIL drain_enter: got st=%0d addr=%h req=%b want %0d/01/1", dbg_state, ifc.imem_addr, ifc.imem_req, ST_DRAIN); end
        tick;
        tests_run++; if (ifc.imem_addr !== 8'h01 || ifc.ir_valid !== 1'b0) begin failed++; $display("FAIL drain_hold: got addr=%h v=%b want 01/0", ifc.imem_addr, ifc.ir_valid); end
        ifc.imem_ack = 1'b1;
        tick;
        tests_run++; if (ifc.imem_addr !== 8'h40 || ifc.ir_valid !== 1'b0 || ifc.imem_req !== 1'b1) begin failed++; $display("FAIL drain_exit: got addr=%h v=%b req=%b want 40/0/1", ifc.imem_addr, ifc.ir_valid, ifc.imem_req); end
        tick;
        tests_run++; if (ifc.ir !== mem[8'h40] || ifc.npc !== 8'h41 || ifc.ir_valid !== 1'b1) begin failed++; $display("FAIL drain_ir: got %h/%h want %h/41", ifc.ir, ifc.npc, mem[8'h40]); end
    endtask

    task automatic test_drain_overwrite;
        ifc.imem_ack = 1'b0; ifc.ir_ready = 1'b1;
        tick;
        ifc.ir_ready = 1'b0; ifc.redirect = 1'b1; ifc.target = 8'h50;
        tick;
        ifc.target = 8'h60;
        tick;
        ifc.redirect = 1'b0;
        tests_run++; if (ifc.imem_addr !== 8'h41 || dbg_state !== ST_DRAIN) begin failed++; $display("FAIL ovr_hold: got addr=%h st=%0d want 41/%0d", ifc.imem_addr, dbg_state, ST_DRAIN); end
        ifc.imem_ack = 1'b1;
        tick;
        tests_run++; if (ifc.imem_addr !== 8'h60 || ifc.ir_valid !== 1'b0) begin failed++; $display("FAIL ovr_target: got addr=%h v=%b want 60/0", ifc.imem_addr, ifc.ir_valid); end
        ifc.redirect = 1'b1; ifc.target = 8'h70;
        tick;
        ifc.redirect = 1'b0;
        tests_run++; if (ifc.imem_addr !== 8'h70 || ifc.ir_valid !== 1'b0 || dbg_state !== ST_REQ) begin failed++; $display("FAIL req_ack_redir: got addr=%h v=%b st=%0d want 70/0/%0d", ifc.imem_addr, ifc.ir_valid, dbg_state, ST_REQ); end
        tick;
        tests_run++; if (ifc.ir !== mem[8'h70] || ifc.npc !== 8'h71 || ifc.ir_valid !== 1'b1) begin failed++; $display("FAIL req_ack_ir: got %h/%h want %h/71", ifc.ir, ifc.npc, mem[8'h70]); end
    endtask

    task automatic test_stream;
        logic [7:0]  a;
        logic [23:0] e;
        int          budget;
        exp_q.delete();
        exp_q.push_back({8'h71, mem[8'h70]});
        for (int i = 1; i <= 20; i++) begin
            a = 8'h70 + 8'(i);
            exp_q.push_back({a + 8'd1, mem[a]});
        end
        budget = 0;
        while (exp_q.size() > 0 && budget < 600) begin
            ifc.imem_ack = 1'($urandom_range(0, 1));
            ifc.ir_ready = 1'($urandom_range(0, 1));
            if (ifc.ir_valid && ifc.ir_ready) begin
                e = exp_q.pop_front();
                tests_run++;
                if (ifc.ir !== e[15:0] || ifc.npc !== e[23:16] || ifc.is_branch !== exp_br(e[15:0])) begin
                    failed++; $display("FAIL stream: got ir=%h npc=%h br=%b want %h/%h/%b", ifc.ir, ifc.npc, ifc.is_branch, e[15:0], e[23:16], exp_br(e[15:0]));
                end
            end
            tick;
            budget++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin failed++; $display("FAIL stream_timeout: got %0d left want 0", exp_q.size()); end
        ifc.ir_ready = 1'b0;
    endtask

    task automatic test_reset_midflight;
        ifc.imem_ack = 1'b0;
        tick;
        tests_run++; if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 8'h85) begin failed++; $display("FAIL mid_req: got req=%b addr=%h want 1/85", ifc.imem_req, ifc.imem_addr); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (ifc.imem_req !== 1'b0 || ifc.ir_valid !== 1'b0 || ifc.imem_addr !== 8'h00 || ifc.ir !== 16'h0000 || ifc.npc !== 8'h00) begin
            failed++; $display("FAIL mid_async: got req=%b v=%b addr=%h ir=%h npc=%h want 0/0/00/0000/00", ifc.imem_req, ifc.ir_valid, ifc.imem_addr, ifc.ir, ifc.npc);
        end
        ifc.imem_ack = 1'b1;
        tick;
        rst_n = 1'b1;
        tests_run++; if (ifc.ir_valid !== 1'b0 || dbg_state !== ST_IDLE) begin failed++; $display("FAIL mid_release: got v=%b st=%0d want 0/%0d", ifc.ir_valid, dbg_state, ST_IDLE); end
        tick;
        tests_run++; if (ifc.ir_valid !== 1'b0 || ifc.imem_addr !== 8'h00) begin failed++; $display("FAIL mid_stale: got v=%b addr=%h want 0/00", ifc.ir_valid, ifc.imem_addr); end
        tick;
        tests_run++; if (ifc.ir !== 16'hA005 || ifc.ir_valid !== 1'b1) begin failed++; $display("FAIL mid_refetch: got %h v=%b want a005/1", ifc.ir, ifc.ir_valid); end
    endtask

    task automatic test_idle_redirect;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1; ifc.redirect = 1'b1; ifc.target = 8'h90;
        tick;
        ifc.redirect = 1'b0;
        tests_run++; if (ifc.imem_addr !== 8'h90 || ifc.imem_req !== 1'b1) begin failed++; $display("FAIL idle_redir: got addr=%h req=%b want 90/1", ifc.imem_addr, ifc.imem_req); end
        tick;
        tests_run++; if (ifc.ir !== mem[8'h90] || ifc.npc !== 8'h91) begin failed++; $display("FAIL idle_redir_ir: got %h/%h want %h/91", ifc.ir, ifc.npc, mem[8'h90]); end
    endtask

    initial begin
        tests_run = 0;
        failed    = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 65535));
        mem[0] = 16'hA005;
        rst_n = 1'b0;
        ifc.imem_ack = 1'b0;
        ifc.ir_ready = 1'b0;
        ifc.redirect = 1'b0;
        ifc.target   = 8'h00;
        test_reset;
        test_first_fetch;
        test_hold;
        test_redirect_valid;
        test_wrap;
        test_redirect_req;
        test_drain_overwrite;
        test_stream;
        test_reset_midflight;
        test_idle_redirect;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_addr  output  8  instruction memory address.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_ack  input  1  memory has placed imem_data for the current request.
REQ-007 imem_data  input  16  instruction word returned by memory.
REQ-008 ir  output  16  fetched instruction word to the branch/decode stage.
REQ-009 npc  output  8  fetch address of ir plus 1.
REQ-010 ir_valid  output  1  ir/npc hold a valid instruction.
REQ-011 ir_ready  input  1  downstream accepts ir this cycle.
REQ-012 is_branch  output  1  ir[15:11] is a branch/jump opcode (BNE..JR, 5'b10011..5'b11000).
REQ-013 redirect  input  1  taken branch/jump; fetch restarts at target.
REQ-014 target  input  8  redirect address.

Function
REQ-015 The block SHALL implement the FSM states IDLE, REQ, DRAIN and VALID, with all outputs registered or decoded from state.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then enter REQ.
REQ-017 In REQ and DRAIN, imem_req SHALL be 1; imem_addr SHALL equal pc and stay stable until imem_ack.
REQ-018 In REQ with imem_ack=1 and redirect=0: ir<=imem_data, npc<=pc+1, pc<=pc+1, state->VALID; minimum fetch latency is 1 cycle (ack in the first REQ cycle).
REQ-019 Address arithmetic SHALL be 8-bit modulo: pc 8'hFF increments to 8'h00.
REQ-020 ir_valid SHALL be 1 only in VALID; ir, npc and is_branch SHALL be held while ir_valid=1 and ir_ready=0.
REQ-021 In VALID with ir_ready=1 and redirect=0, state->REQ next cycle.
REQ-022 redirect in VALID (with or without ir_ready) SHALL set pc<=target, state->REQ, and drop ir_valid the next cycle.
REQ-023 redirect in REQ with imem_ack=1 SHALL discard imem_data, set pc<=target, and remain in REQ.
REQ-024 redirect in REQ with imem_ack=0 SHALL latch target as pending, keep imem_addr unchanged and enter DRAIN.
REQ-025 In DRAIN, a further redirect SHALL overwrite the pending target; on imem_ack the data SHALL be discarded, pc<=pending target (or the newer redirect target if asserted that cycle), state->REQ.
REQ-026 redirect in IDLE SHALL set pc<=target; the first request then uses target.
REQ-027 is_branch SHALL be computed from ir and be 0 whenever ir_valid=0.

Reset
REQ-028 While rst_n=0: state=IDLE, pc=RESET_PC, pending target=8'h00, ir=16'h0000, npc=8'h00, ir_valid=0, imem_req=0, is_branch=0; imem_addr=RESET_PC.
REQ-029 Reset asserted mid-transaction SHALL abandon the request immediately; no ir_valid SHALL be produced for it.

Structure
REQ-030 Opcode constants (BNE, BE, BNER, BER, J, JR) and the FSM state encoding SHALL reside in the shared processor package used by the branch unit.
REQ-031 The 8-bit PC register with increment/load SHALL be one sub-module, pc_reg.

Verification
REQ-032 Reset release, RESET_PC=8'h00, imem_ack=1 every cycle, mem[0]=16'hA005 -> imem_req high 1 cycle after release at addr 8'h00; next cycle ir=16'hA005, npc=8'h01, ir_valid=1, is_branch=1.
REQ-033 ir_ready=0 for 3 cycles in VALID -> ir/npc/ir_valid unchanged, imem_req=0; ir_ready=1 -> REQ at next address.
REQ-034 pc=8'hFF fetched -> npc=8'h00, next imem_addr=8'h00.
REQ-035 Redirect target=8'h40 in REQ with imem_ack delayed 2 cycles -> imem_addr held at old address, returned data dropped (ir_valid stays 0), next request at 8'h40.
REQ-036 Redirect target=8'h20 in VALID together with ir_ready=1 -> ir_valid=0 next cycle, next request at 8'h20, npc of the following instruction=8'h21.
REQ-037 rst_n driven low while waiting for imem_ack -> all outputs at reset values asynchronously, no stale ir_valid after release.
